// File: rtl/cog_pxs_pkg.sv
// Shared constants, register field layout and state encoding for the cog pixel shifter.
package cog_pxs_pkg;

    localparam int unsigned MODE_W     = 2;
    localparam int unsigned GRP_W      = 3;
    localparam int unsigned MASK_W     = 8;
    localparam int unsigned PCLKS_W    = 8;
    localparam int unsigned FCLKS_W    = 12;
    localparam int unsigned PCNT_W     = 9;
    localparam int unsigned FCNT_W     = 13;
    localparam int unsigned WORD_W     = 32;

    localparam int unsigned VCFG_MODE_LSB  = 29;
    localparam int unsigned VCFG_GRP_LSB   = 9;
    localparam int unsigned VCFG_MASK_LSB  = 0;
    localparam int unsigned VSCL_PCLKS_LSB = 12;
    localparam int unsigned VSCL_FCLKS_LSB = 0;

    localparam int unsigned PCLKS_ZERO = 256;
    localparam int unsigned FCLKS_ZERO = 4096;

    localparam logic [MODE_W-1:0] MODE_OFF  = 2'b00;
    localparam logic [MODE_W-1:0] MODE_1BPP = 2'b01;
    localparam logic [MODE_W-1:0] MODE_2BPP = 2'b10;

    typedef enum logic [1:0] {
        OFF  = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2
    } pxs_state_e;

    function automatic logic is_run_mode(input logic [MODE_W-1:0] mode);
        return (mode == MODE_1BPP) || (mode == MODE_2BPP);
    endfunction

    // Colour index taken from the bottom of the shift register.
    function automatic logic [1:0] pix_index(input logic [MODE_W-1:0] mode, input logic [1:0] low);
        return (mode == MODE_2BPP) ? low : {1'b0, low[0]};
    endfunction

endpackage

// File: rtl/cog_pxs_sync.sv
// Synchronises the asynchronous pixel-clock tick and emits a one-cycle step on its rising edge.
module cog_pxs_sync #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk_cog,
    input  logic ena,
    input  logic tick,
    output logic step_c
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   hist_q;

    always_ff @(posedge clk_cog or negedge ena) begin
        if (!ena) begin
            sync_q <= '0;
            hist_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], tick};
            hist_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign step_c = sync_q[SYNC_STAGES-1] & ~hist_q;

endmodule

// File: rtl/cog_pxs.sv
// Per-cog pixel shifter: serialises latched pixel words into colour bytes on one 8-pin group.
module cog_pxs
    import cog_pxs_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic        clk_cog,
    input  logic        ena,
    input  logic        setvcfg,
    input  logic        setvscl,
    input  logic [31:0] data,
    input  logic        tick,
    input  logic        vid_req,
    input  logic [31:0] colors,
    input  logic [31:0] pixels,
    output logic        vid_ack,
    output logic        busy,
    output logic [31:0] pin_out
);

    logic [MODE_W-1:0]  mode_q, mode_n;
    logic [GRP_W-1:0]   grp_q;
    logic [MASK_W-1:0]  mask_q;
    logic [PCLKS_W-1:0] pclks_q, pclks_n;
    logic [FCLKS_W-1:0] fclks_q, fclks_n;
    logic [PCNT_W-1:0]  pcnt_q, pcnt_d, pclks_ext;
    logic [FCNT_W-1:0]  fcnt_q, fcnt_d, fclks_ext;
    logic [WORD_W-1:0]  colors_q, colors_d, pix_q, pix_d, shf_q, shf_d, shf_adv;
    logic [WORD_W-1:0]  pin_d;
    pxs_state_e         state_q, state_d;
    logic               ack_d, req_v, step_c;
    logic [1:0]         idx_c;
    logic [7:0]         byte_c;
    logic               unused_data_c;

    assign unused_data_c = ^{data[31], data[28:20]};

    cog_pxs_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk_cog (clk_cog),
        .ena     (ena),
        .tick    (tick),
        .step_c  (step_c)
    );

    // A register write in the same cycle as a step takes precedence over the old value.
    assign mode_n    = setvcfg ? data[VCFG_MODE_LSB +: MODE_W] : mode_q;
    assign pclks_n   = setvscl ? data[VSCL_PCLKS_LSB +: PCLKS_W] : pclks_q;
    assign fclks_n   = setvscl ? data[VSCL_FCLKS_LSB +: FCLKS_W] : fclks_q;
    assign pclks_ext = (pclks_n == '0) ? PCNT_W'(PCLKS_ZERO) : PCNT_W'(pclks_n);
    assign fclks_ext = (fclks_n == '0) ? FCNT_W'(FCLKS_ZERO) : FCNT_W'(fclks_n);
    assign shf_adv   = (mode_n == MODE_2BPP) ? {2'b00, shf_q[WORD_W-1:2]} : {1'b0, shf_q[WORD_W-1:1]};
    assign req_v     = vid_req & ~vid_ack;

    always_comb begin
        state_d  = state_q;
        pcnt_d   = pcnt_q;
        fcnt_d   = fcnt_q;
        colors_d = colors_q;
        pix_d    = pix_q;
        shf_d    = shf_q;
        ack_d    = 1'b0;
        if (!is_run_mode(mode_n)) begin
            state_d = OFF;
            pcnt_d  = '0;
            fcnt_d  = '0;
            ack_d   = req_v;
        end else begin
            case (state_q)
                OFF, LOAD: begin
                    state_d = LOAD;
                    if (step_c) begin
                        if (req_v) begin
                            colors_d = colors;
                            pix_d    = pixels;
                            shf_d    = pixels;
                            ack_d    = 1'b1;
                        end else begin
                            shf_d    = pix_q;
                        end
                        pcnt_d  = pclks_ext;
                        fcnt_d  = fclks_ext;
                        state_d = RUN;
                    end
                end
                RUN: begin
                    if (step_c) begin
                        pcnt_d = pcnt_q - PCNT_W'(1);
                        fcnt_d = fcnt_q - FCNT_W'(1);
                        if (pcnt_q == PCNT_W'(1)) begin
                            pcnt_d = pclks_ext;
                            shf_d  = shf_adv;
                        end
                        if (fcnt_q == FCNT_W'(1)) begin
                            state_d = LOAD;
                        end
                    end
                end
                default: state_d = OFF;
            endcase
        end
    end

    // Output byte is formed from registered state, so it lands one clock after the step.
    assign idx_c  = pix_index(mode_q, shf_q[1:0]);
    assign byte_c = colors_q[{idx_c, 3'b000} +: 8];
    assign pin_d  = (state_q != OFF && is_run_mode(mode_q))
                  ? (WORD_W'(byte_c & mask_q) << {grp_q, 3'b000}) : '0;

    always_ff @(posedge clk_cog or negedge ena) begin
        if (!ena) begin
            mode_q   <= MODE_OFF;
            grp_q    <= '0;
            mask_q   <= '0;
            pclks_q  <= '0;
            fclks_q  <= '0;
            state_q  <= OFF;
            pcnt_q   <= '0;
            fcnt_q   <= '0;
            colors_q <= '0;
            pix_q    <= '0;
            shf_q    <= '0;
            vid_ack  <= 1'b0;
            busy     <= 1'b0;
            pin_out  <= '0;
        end else begin
            if (setvcfg) begin
                mode_q <= data[VCFG_MODE_LSB +: MODE_W];
                grp_q  <= data[VCFG_GRP_LSB +: GRP_W];
                mask_q <= data[VCFG_MASK_LSB +: MASK_W];
            end
            pclks_q  <= pclks_n;
            fclks_q  <= fclks_n;
            state_q  <= state_d;
            pcnt_q   <= pcnt_d;
            fcnt_q   <= fcnt_d;
            colors_q <= colors_d;
            pix_q    <= pix_d;
            shf_q    <= shf_d;
            vid_ack  <= ack_d;
            busy     <= (state_d == RUN);
            pin_out  <= pin_d;
        end
    end

endmodule
